// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder definitions: format codes, opcode classes (instr[6:2]) and the
// request record carried through the pipeline.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    // True when v[31:lsb] are all copies of one bit, i.e. v fits a signed (lsb+1)-bit field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> lsb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational immediate scatter: places immediate bits at their RV32I instruction
// positions for the given format and flags immediates that do not fit.
module imm_scatter
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_word,
    output logic        range_err
);

    always_comb begin
        imm_word  = '0;
        range_err = 1'b0;
        case (fmt)
            FMT_R: begin
                imm_word  = '0;
                range_err = 1'b0;
            end
            FMT_I: begin
                imm_word  = {imm[11:0], 20'b0};
                range_err = !fits_signed(imm, 11);
            end
            FMT_S: begin
                imm_word  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                range_err = !fits_signed(imm, 11);
            end
            FMT_B: begin
                imm_word  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                range_err = imm[0] || !fits_signed(imm, 12);
            end
            FMT_U: begin
                imm_word  = {imm[31:12], 12'b0};
                range_err = |imm[11:0];
            end
            FMT_J: begin
                imm_word  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                range_err = imm[0] || !fits_signed(imm, 20);
            end
            default: begin
                imm_word  = '0;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I instruction encoder with valid/ready on both sides,
// immediate range checking and a saturating count of errored output words.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [4:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    req_t  in_req;
    req_t  s1_req;
    logic  s1_valid;
    logic  s2_valid;
    logic  [31:0] s2_instr;
    logic  s2_err;
    logic  s1_adv;
    logic  s2_adv;
    logic  [31:0] imm_word;
    logic  range_err;
    logic  [31:0] fields;
    logic  [31:0] packed_word;

    assign in_req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    // Reset clears both valids, so s1_adv alone would be high during reset.
    assign in_ready = s1_adv && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_req <= in_req;
            end
        end
    end

    imm_scatter u_imm_scatter (
        .fmt       (s1_req.fmt),
        .imm       (s1_req.imm),
        .imm_word  (imm_word),
        .range_err (range_err)
    );

    always_comb begin
        fields = '0;
        case (s1_req.fmt)
            FMT_R:        fields = {s1_req.funct7, s1_req.rs2, s1_req.rs1, s1_req.funct3,
                                    s1_req.rd, s1_req.opcode, 2'b11};
            FMT_I:        fields = {12'b0, s1_req.rs1, s1_req.funct3, s1_req.rd,
                                    s1_req.opcode, 2'b11};
            FMT_S, FMT_B: fields = {7'b0, s1_req.rs2, s1_req.rs1, s1_req.funct3, 5'b0,
                                    s1_req.opcode, 2'b11};
            FMT_U, FMT_J: fields = {20'b0, s1_req.rd, s1_req.opcode, 2'b11};
            default:      fields = '0;
        endcase
        packed_word = fields | imm_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= packed_word;
                s2_err   <= range_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (s2_valid && out_ready && s2_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder. It is the inverse of the decode-side immediate generator: it takes an instruction format, its fields and a 32-bit immediate, and scatters the immediate bits into a 32-bit instruction word.
- Used by the self-test/boot-ROM generator and the verification stimulus path to produce instruction words for the fetch/decode stage.
- 2-stage pipeline with valid/ready handshake on both sides, immediate range checking, and a saturating error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating range-error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are invalid.
- in_opcode  in  5  instr[6:2] opcode class; uses the shared opcode macros.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R format only).
- in_imm  in  32  byte-offset/immediate value, two's complement.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction.
- out_err  out  1  qualifies out_instr: immediate out of range or invalid fmt.
- err_cnt  out  ERR_CNT_W  saturating count of errored words delivered.

Behaviour:
- Async reset, effective immediately: s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, err_cnt=0. Any in-flight data is discarded.
- in_ready is high while rst is asserted is not allowed; in_ready=0 during reset.
- Stage 1 (S1) registers the fields and computes the range check.
- Stage 2 (S2) registers the packed word and the error flag, and drives the outputs.
- Latency: 2 cycles from accept to out_valid. Throughput: 1 word/cycle when out_ready=1.
- Backpressure:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - With out_ready held low, the pipeline holds at most 2 words. Registers must not change while stalled.
  - Order is preserved; no drops, no duplicates.
- out_instr and out_err hold stable while out_valid && !out_ready.
- Range checks (err=1 on failure):
  - I, S: in_imm[31:11] all equal.
  - B: in_imm[0]==0 and in_imm[31:12] all equal.
  - U: in_imm[11:0]==0.
  - J: in_imm[0]==0 and in_imm[31:20] all equal.
  - R: immediate ignored, no error.
  - fmt 6 or 7: err=1 and out_instr=0.
- Packing (instr[1:0]=2'b11 and instr[6:2]=in_opcode in every format):
  - R: {f7, rs2, rs1, f3, rd}
  - I: {imm[11:0], rs1, f3, rd}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0]}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}
  - U: {imm[31:12], rd}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}
- On a range error the word is still packed from truncated bits (except invalid fmt); out_err marks it.
- err_cnt increments by 1 on each output handshake (out_valid && out_ready) with out_err=1. It saturates at all-ones and clears only on reset.
- The format is not validated against the opcode; the caller is responsible for consistency.

Decomposition:
- Shared `define include (the same file as the opcode-class macros): format codes FMT_R..FMT_J and the opcode-class constants.
- One combinational sub-module, imm_scatter: takes fmt and imm, produces the immediate bit-field mask/word and the range-error flag.
- The pipeline and handshake logic stay in instr_encoder.

Test Plan:
- I, opcode=5'b00100, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF -> out_instr=0xFFF10093, out_err=0, out_valid exactly 2 cycles after accept.
- B, opcode=5'b11000, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463. Then U lui rd=5, imm=0x12345000 -> 0x123452B7. Then J rd=1, imm=0x800 -> 0x001000EF. Sent back-to-back, results in order, one per cycle.
- B with imm=3, then I with imm=0x800 -> both have out_err=1 and err_cnt=2. fmt=7 -> out_instr=0, out_err=1.
- out_ready=0 for 6 cycles while 4 valid requests are offered -> exactly 2 accepted and in_ready=0 thereafter. Releasing out_ready drains all 4 in order with no loss.
- Force err_cnt to saturate with 260 errored words (ERR_CNT_W=8) -> err_cnt stays 0xFF.
- Assert rst with 2 words in flight -> out_valid=0 and err_cnt=0 within the same cycle (async). After rst deasserts, a fresh request encodes correctly.
